// File: rtl/amo_pkg.sv
// amo_pkg -- shared definitions for the atomic-memory-operation controller.
//   * XLEN default width macro (overridable from the command line)
//   * funct5 encodings for LR/SC and the AMO family
//   * controller state enum, exported to the debug port of amo_ctrl
//   * helpers that classify a funct5 value
`ifndef XLEN
`define XLEN 32
`endif

package amo_pkg;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_supported(input logic [4:0] f);
    case (f)
      F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: is_supported = 1'b1;
      default:                          is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/amo_ctrl_if.sv
// amo_ctrl_if -- memory port of the atomic controller.
// Handshake: o_mem_req is held high with o_mem_addr/o_mem_we/o_mem_wdata
// stable until a cycle in which i_mem_ack is high; that cycle completes the
// transfer (read data is taken from i_mem_rdata in the same cycle). An ack
// seen while o_mem_req is low has no effect.
//   master : controller side (drives request, receives ack/rdata)
//   slave  : memory side
`ifndef XLEN
`define XLEN 32
`endif

interface amo_ctrl_if #(
  parameter int XLEN = `XLEN
);
  logic            o_mem_req;
  logic            o_mem_we;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [XLEN-1:0] i_mem_rdata;
  logic            i_mem_ack;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ack
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ack
  );
endinterface

// File: rtl/amo_alu.sv
// amo_alu -- combinational read-modify-write operator for AMOs.
//   op     : funct5 of the AMO
//   a      : value loaded from memory
//   b      : rs2 operand
//   result : value to store back (SWAP and unknown ops return b)
`ifndef XLEN
`define XLEN 32
`endif

module amo_alu
  import amo_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = b;
    case (op)
      F5_ADD:  result = a + b;
      F5_XOR:  result = a ^ b;
      F5_AND:  result = a & b;
      F5_OR:   result = a | b;
      F5_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
      F5_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
      F5_MINU: result = (a < b) ? a : b;
      F5_MAXU: result = (a > b) ? a : b;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/amo_ctrl.sv
// amo_ctrl -- sequences RISC-V A-extension operations (LR, SC, AMOs) onto a
// single-port memory and drives a reservation table.
//   i_clk/i_rst            : clock, synchronous active-high reset
//   i_req..i_rs2, o_ready  : operation request, taken when i_req && o_ready
//   o_done/o_rd_data/o_err : one-cycle completion with rd result / error flag
//   mem                    : memory request port (amo_ctrl_if.master)
//   o_set_res/o_check_res/o_wr_en, o_res_id/o_res_addr, i_gnt
//                          : reservation-table pulses, key and SC grant
//   o_state                : current controller state (debug)
`ifndef XLEN
`define XLEN 32
`endif

module amo_ctrl
  import amo_pkg::*;
#(
  parameter int  XLEN  = `XLEN,
  parameter int  N_IDS = 1,
  localparam int ID_W  = (N_IDS > 1) ? $clog2(N_IDS) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic [4:0]      i_funct5,
  input  logic [ID_W-1:0] i_id,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_ready,
  output logic            o_done,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_err,
  amo_ctrl_if.master      mem,
  output logic            o_set_res,
  output logic            o_check_res,
  output logic            o_wr_en,
  output logic [ID_W-1:0] o_res_id,
  output logic [XLEN-1:0] o_res_addr,
  input  logic            i_gnt,
  output state_t          o_state
);

  state_t          state_q, state_d;
  logic [4:0]      funct5_q;
  logic [ID_W-1:0] id_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] rd_q;     // loaded value for LR/AMO, SC status for SC
  logic            err_q;
  logic [XLEN-1:0] alu_result;

  logic accept;
  logic bad_req;

  assign accept  = (state_q == ST_IDLE) && i_req;
  assign bad_req = (i_addr[1:0] != 2'b00) || !is_supported(i_funct5);
  assign o_state = state_q;

  amo_alu #(.XLEN(XLEN)) u_alu (
    .op     (funct5_q),
    .a      (rd_q),
    .b      (rs2_q),
    .result (alu_result)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          if (bad_req)                state_d = ST_DONE;
          else if (i_funct5 == F5_SC) state_d = ST_CHECK;
          else                        state_d = ST_LOAD;
        end
      end
      ST_LOAD:  if (mem.i_mem_ack) state_d = (funct5_q == F5_LR) ? ST_DONE : ST_STORE;
      ST_CHECK: state_d = i_gnt ? ST_STORE : ST_DONE;
      ST_STORE: if (mem.i_mem_ack) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operation latches
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      funct5_q <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        funct5_q <= i_funct5;
        id_q     <= i_id;
        addr_q   <= i_addr;
        rs2_q    <= i_rs2;
        rd_q     <= '0;
        err_q    <= bad_req;
      end else if (state_q == ST_LOAD && mem.i_mem_ack) begin
        rd_q <= mem.i_mem_rdata;
      end else if (state_q == ST_CHECK) begin
        // SC reports 0 on success, 1 on failure
        rd_q <= i_gnt ? '0 : XLEN'(1);
      end
    end
  end

  // Outputs, decoded from the current state only (plus same-cycle ack for pulses)
  always_comb begin
    o_ready         = 1'b0;
    o_done          = 1'b0;
    o_rd_data       = '0;
    o_err           = 1'b0;
    o_set_res       = 1'b0;
    o_check_res     = 1'b0;
    o_wr_en         = 1'b0;
    o_res_id        = '0;
    o_res_addr      = '0;
    mem.o_mem_req   = 1'b0;
    mem.o_mem_we    = 1'b0;
    mem.o_mem_addr  = '0;
    mem.o_mem_wdata = '0;
    if (state_q != ST_IDLE) begin
      o_res_id   = id_q;
      o_res_addr = addr_q;
    end
    case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_LOAD: begin
        mem.o_mem_req  = 1'b1;
        mem.o_mem_addr = addr_q;
        o_set_res      = mem.i_mem_ack && (funct5_q == F5_LR);
      end
      ST_CHECK: o_check_res = 1'b1;
      ST_STORE: begin
        mem.o_mem_req   = 1'b1;
        mem.o_mem_we    = 1'b1;
        mem.o_mem_addr  = addr_q;
        mem.o_mem_wdata = (funct5_q == F5_SC) ? rs2_q : alu_result;
        o_wr_en         = mem.i_mem_ack;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        o_rd_data = rd_q;
        o_err     = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_amo_ctrl.sv
// tb_amo_ctrl -- self-checking bench for amo_ctrl: directed scenarios plus
// randomized operations compared against an operation-level reference model.
module tb_amo_ctrl;
  import amo_pkg::*;

  localparam int XLEN  = 32;
  localparam int N_IDS = 4;
  localparam int ID_W  = 2;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic            i_req;
  logic [4:0]      i_funct5;
  logic [ID_W-1:0] i_id;
  logic [XLEN-1:0] i_addr, i_rs2;
  logic            o_ready, o_done, o_err;
  logic [XLEN-1:0] o_rd_data;
  logic            o_set_res, o_check_res, o_wr_en;
  logic [ID_W-1:0] o_res_id;
  logic [XLEN-1:0] o_res_addr;
  logic            i_gnt;
  state_t          dbg_state;

  amo_ctrl_if #(.XLEN(XLEN)) mem_bus ();

  amo_ctrl #(.XLEN(XLEN), .N_IDS(N_IDS)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_funct5    (i_funct5),
    .i_id        (i_id),
    .i_addr      (i_addr),
    .i_rs2       (i_rs2),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_rd_data   (o_rd_data),
    .o_err       (o_err),
    .mem         (mem_bus),
    .o_set_res   (o_set_res),
    .o_check_res (o_check_res),
    .o_wr_en     (o_wr_en),
    .o_res_id    (o_res_id),
    .o_res_addr  (o_res_addr),
    .i_gnt       (i_gnt),
    .o_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] mem_arr [logic [31:0]];

  localparam logic [4:0] OPS [11] = '{F5_LR, F5_SC, F5_SWAP, F5_ADD, F5_XOR,
                                      F5_AND, F5_OR, F5_MIN, F5_MAX, F5_MINU, F5_MAXU};

  typedef struct {
    logic [31:0] rd;
    bit          err;
    int          n_read;
    int          n_write;
    logic [31:0] wdata;
    int          n_set;
    int          n_check;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit op_known(input logic [4:0] f);
    bit k = 0;
    foreach (OPS[i]) if (OPS[i] == f) k = 1;
    return k;
  endfunction

  function automatic logic [31:0] amo_value(input logic [4:0] f, input logic [31:0] mv, input logic [31:0] rv);
    longint sa = $signed(mv);
    longint sb = $signed(rv);
    longint ua = {32'b0, mv};
    longint ub = {32'b0, rv};
    longint sum = ua + ub;
    logic [31:0] v;
    case (f)
      F5_SWAP: v = rv;
      F5_ADD:  v = sum[31:0];
      F5_XOR:  v = mv ^ rv;
      F5_AND:  v = mv & rv;
      F5_OR:   v = mv | rv;
      F5_MIN:  v = (sa <= sb) ? mv : rv;
      F5_MAX:  v = (sa >= sb) ? mv : rv;
      F5_MINU: v = (ua <= ub) ? mv : rv;
      F5_MAXU: v = (ua >= ub) ? mv : rv;
      default: v = 32'hx;
    endcase
    return v;
  endfunction

  // Latency counts the accept cycle through the done cycle inclusive.
  function automatic exp_t ref_model(input logic [4:0] f, input logic [31:0] addr,
                                     input logic [31:0] rs2, input logic [31:0] old,
                                     input bit gnt, input int d1, input int d2);
    exp_t e;
    e.rd = 0; e.err = 0; e.n_read = 0; e.n_write = 0; e.wdata = 0;
    e.n_set = 0; e.n_check = 0; e.lat = 2;
    if (addr[1:0] != 2'b00 || !op_known(f)) begin
      e.err = 1;
    end else if (f == F5_LR) begin
      e.rd = old; e.n_read = 1; e.n_set = 1; e.lat = 3 + d1;
    end else if (f == F5_SC) begin
      e.n_check = 1;
      if (gnt) begin e.n_write = 1; e.wdata = rs2; e.rd = 0; e.lat = 4 + d1; end
      else     begin e.rd = 1; e.lat = 3; end
    end else begin
      e.rd = old; e.n_read = 1; e.n_write = 1; e.wdata = amo_value(f, old, rs2);
      e.lat = 4 + d1 + d2;
    end
    return e;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic run_op(input string tag, input logic [4:0] f, input logic [ID_W-1:0] id,
                        input logic [31:0] addr, input logic [31:0] rs2, input bit gnt,
                        input int d1, input int d2);
    exp_t e;
    logic [31:0] old;
    int waitc = 0, phase = 0, lat = 2;
    int n_rd = 0, n_wr = 0, n_set = 0, n_chk = 0, n_wen = 0;
    logic [31:0] wdata_seen = 0, rd_seen = 0;
    logic err_seen = 0;
    bit done_seen = 0, in_phase = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;
    logic p_we = 0;
    old = mem_arr.exists(addr) ? mem_arr[addr] : 32'h0;
    e = ref_model(f, addr, rs2, old, gnt, d1, d2);

    @(negedge i_clk);
    chk({tag, ".ready"}, o_ready, 1);
    i_req = 1; i_funct5 = f; i_id = id; i_addr = addr; i_rs2 = rs2; i_gnt = gnt;
    @(negedge i_clk);
    i_req = 0; i_funct5 = 5'($urandom); i_addr = $urandom; i_rs2 = $urandom; i_id = 2'($urandom);
    for (int c = 0; c < 60; c++) begin
      mem_bus.i_mem_ack   = 0;
      mem_bus.i_mem_rdata = $urandom;
      chk({tag, ".res_addr"}, o_res_addr, addr);
      chk({tag, ".res_id"}, o_res_id, id);
      if (o_done) begin
        done_seen = 1; rd_seen = o_rd_data; err_seen = o_err;
        break;
      end
      if (mem_bus.o_mem_req) begin
        if (!in_phase) begin
          in_phase = 1; waitc = 0;
          p_addr = mem_bus.o_mem_addr; p_we = mem_bus.o_mem_we; p_wdata = mem_bus.o_mem_wdata;
        end else begin
          chk({tag, ".stable_addr"}, mem_bus.o_mem_addr, p_addr);
          chk({tag, ".stable_we"}, mem_bus.o_mem_we, p_we);
          chk({tag, ".stable_wdata"}, mem_bus.o_mem_wdata, p_wdata);
        end
        chk({tag, ".mem_addr"}, mem_bus.o_mem_addr, addr);
        if (waitc == ((phase == 0) ? d1 : d2)) begin
          mem_bus.i_mem_ack = 1;
          if (!mem_bus.o_mem_we) begin
            mem_bus.i_mem_rdata = mem_arr[addr];
            n_rd++;
          end else begin
            wdata_seen = mem_bus.o_mem_wdata;
            mem_arr[addr] = mem_bus.o_mem_wdata;
            n_wr++;
          end
          in_phase = 0; phase++;
        end else begin
          waitc++;
        end
      end
      #1;
      n_set += int'(o_set_res);
      n_chk += int'(o_check_res);
      n_wen += int'(o_wr_en);
      @(negedge i_clk);
      lat++;
    end
    mem_bus.i_mem_ack = 0;
    chk({tag, ".done_seen"}, done_seen, 1);
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".rd"}, rd_seen, e.rd);
    chk({tag, ".err"}, err_seen, e.err);
    chk({tag, ".n_read"}, n_rd, e.n_read);
    chk({tag, ".n_write"}, n_wr, e.n_write);
    if (e.n_write != 0) chk({tag, ".wdata"}, wdata_seen, e.wdata);
    chk({tag, ".set_res"}, n_set, e.n_set);
    chk({tag, ".check_res"}, n_chk, e.n_check);
    chk({tag, ".wr_en"}, n_wen, e.n_write);
    @(negedge i_clk);
    chk({tag, ".done_one_cycle"}, o_done, 0);
    chk({tag, ".ready_after"}, o_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst = 1; i_req = 0; i_funct5 = 0; i_id = 0; i_addr = 0; i_rs2 = 0; i_gnt = 0;
    mem_bus.i_mem_ack = 0; mem_bus.i_mem_rdata = 0;
    for (int i = 0; i < 16; i++) mem_arr[32'h100 + 32'(i * 4)] = $urandom;

    repeat (3) @(negedge i_clk);
    i_rst = 0;
    chk("rst.ready", o_ready, 1);
    chk("rst.done", o_done, 0);
    chk("rst.rd_data", o_rd_data, 0);
    chk("rst.err", o_err, 0);
    chk("rst.mem_req", mem_bus.o_mem_req, 0);
    chk("rst.mem_we", mem_bus.o_mem_we, 0);
    chk("rst.mem_addr", mem_bus.o_mem_addr, 0);
    chk("rst.mem_wdata", mem_bus.o_mem_wdata, 0);
    chk("rst.pulses", {o_set_res, o_check_res, o_wr_en}, 0);
    chk("rst.res_key", {o_res_id, o_res_addr}, 0);

    // LR, then SC pass / SC fail on the same word
    mem_arr[32'h100] = 32'hDEAD_BEEF;
    run_op("lr", F5_LR, 2'd1, 32'h100, 32'h0, 1'b0, 0, 0);
    run_op("sc_pass", F5_SC, 2'd1, 32'h100, 32'h5, 1'b1, 0, 0);
    chk("sc_pass.mem", mem_arr[32'h100], 32'h5);
    run_op("sc_fail", F5_SC, 2'd2, 32'h100, 32'h7, 1'b0, 0, 0);
    chk("sc_fail.mem", mem_arr[32'h100], 32'h5);

    // signed vs unsigned minimum
    mem_arr[32'h104] = 32'hFFFF_FFFF;
    run_op("amomin", F5_MIN, 2'd0, 32'h104, 32'h1, 1'b0, 0, 0);
    chk("amomin.mem", mem_arr[32'h104], 32'hFFFF_FFFF);
    mem_arr[32'h108] = 32'hFFFF_FFFF;
    run_op("amominu", F5_MINU, 2'd0, 32'h108, 32'h1, 1'b0, 0, 0);
    chk("amominu.mem", mem_arr[32'h108], 32'h1);

    // delayed acks in both phases, with wraparound
    mem_arr[32'h10C] = 32'hFFFF_FFFF;
    run_op("amoadd_wait", F5_ADD, 2'd3, 32'h10C, 32'h1, 1'b0, 3, 3);
    chk("amoadd_wait.mem", mem_arr[32'h10C], 32'h0);

    // reset while in STORE abandons the operation
    mem_arr[32'h120] = 32'h5;
    @(negedge i_clk);
    i_req = 1; i_funct5 = F5_ADD; i_id = 2'd1; i_addr = 32'h120; i_rs2 = 32'h3;
    @(negedge i_clk);
    i_req = 0;
    chk("rstop.load_req", mem_bus.o_mem_req, 1);
    mem_bus.i_mem_ack = 1; mem_bus.i_mem_rdata = 32'h5;
    @(negedge i_clk);
    mem_bus.i_mem_ack = 0;
    chk("rstop.store_req", mem_bus.o_mem_req, 1);
    chk("rstop.store_we", mem_bus.o_mem_we, 1);
    chk("rstop.store_wdata", mem_bus.o_mem_wdata, 32'h8);
    i_rst = 1;
    @(negedge i_clk);
    i_rst = 0;
    chk("rstop.req_dropped", mem_bus.o_mem_req, 0);
    chk("rstop.no_done", o_done, 0);
    chk("rstop.ready", o_ready, 1);
    mem_bus.i_mem_ack = 1;  // late ack after reset
    #1;
    chk("rstop.no_wr_en", o_wr_en, 0);
    chk("rstop.no_set_res", o_set_res, 0);
    @(negedge i_clk);
    mem_bus.i_mem_ack = 0;
    chk("rstop.idle", dbg_state, ST_IDLE);
    chk("rstop.no_done2", o_done, 0);
    chk("rstop.req_low2", mem_bus.o_mem_req, 0);

    // misaligned and illegal
    run_op("misaligned", F5_SWAP, 2'd0, 32'h102, 32'h9, 1'b0, 0, 0);
    run_op("illegal", 5'b00101, 2'd2, 32'h110, 32'h9, 1'b1, 0, 0);

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [4:0]  f;
      logic [31:0] a;
      int sel = $urandom_range(0, 13);
      if (sel < 11)       f = OPS[sel];
      else if (sel == 11) f = 5'b11111;
      else                f = OPS[$urandom_range(0, 10)];
      a = 32'h100 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      run_op("rand", f, 2'($urandom), a, $urandom, 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amo_ctrl.md
AMO_CTRL -- requirements
Module: amo_ctrl

Interface
REQ-001 Parameter XLEN, default `XLEN, data/address width.
REQ-002 Parameter N_IDS, default 1, number of hart IDs sharing the reservation table.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  core requests an A-extension op; taken when i_req && o_ready.
REQ-006 i_funct5  in  5  instruction funct5 (LR/SC/AMO encoding).
REQ-007 i_id  in  $clog2(N_IDS)  requesting hart ID.
REQ-008 i_addr  in  XLEN  rs1 effective address.
REQ-009 i_rs2  in  XLEN  rs2 operand.
REQ-010 o_ready  out  1  high only in IDLE.
REQ-011 o_done  out  1  one-cycle completion pulse.
REQ-012 o_rd_data  out  XLEN  rd result, valid with o_done.
REQ-013 o_err  out  1  misaligned/illegal op, valid with o_done.
REQ-014 o_mem_req, o_mem_we  out  1 each  memory request, write enable.
REQ-015 o_mem_addr, o_mem_wdata  out  XLEN each; i_mem_rdata  in  XLEN; i_mem_ack  in  1.
REQ-016 o_set_res, o_check_res, o_wr_en  out  1 each  reservation-table controls (one-cycle pulses).
REQ-017 o_res_id  out  $clog2(N_IDS); o_res_addr  out  XLEN; i_gnt  in  1  combinational grant from table.

Function
REQ-018 FSM states IDLE, LOAD, CHECK, STORE, DONE; one state per cycle minimum.
REQ-019 On accept: latch funct5, id, addr, rs2; o_res_id/o_res_addr driven from latches in all non-IDLE states.
REQ-020 Accept with addr[1:0]!=0 or unsupported funct5 -> DONE, o_err=1, o_rd_data=0; no memory or table activity.
REQ-021 Supported funct5: LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
REQ-022 LR: IDLE->LOAD; read; on ack capture rdata as rd, pulse o_set_res same cycle, ->DONE.
REQ-023 SC: IDLE->CHECK; pulse o_check_res one cycle; i_gnt=1 -> STORE writing rs2, rd=0; i_gnt=0 -> DONE, rd=1, no memory access.
REQ-024 AMO: IDLE->LOAD (read) ->STORE writing alu(rdata,rs2); rd = loaded value.
REQ-025 In STORE, on ack pulse o_wr_en (invalidates all matching reservations) and ->DONE.
REQ-026 o_mem_req held high with stable addr/we/wdata until i_mem_ack; ack may arrive first cycle of req; ack while req low ignored.
REQ-027 DONE: o_done=1 one cycle, ->IDLE; no new accept in DONE.
REQ-028 ALU: ADD modulo 2^XLEN; MIN/MAX signed; MINU/MAXU unsigned; equal operands return either (identical).
REQ-029 Min latency with same-cycle ack: LR/SC-fail 3 cycles accept-to-done, AMO/SC-pass 4 cycles.

Reset
REQ-030 i_rst high: next state IDLE; o_ready=1 after edge; all other outputs 0; latches cleared.
REQ-031 Reset mid-operation abandons the op: o_mem_req drops, no o_done, no table pulse; a late ack after reset is ignored.

Structure
REQ-032 Shared package amo_pkg holds funct5 constants and state enum.
REQ-033 Combinational sub-module amo_alu (op, a, b -> result); FSM and latches in amo_ctrl.

Verification
REQ-034 LR addr 0x100, rdata 0xDEAD_BEEF, ack first cycle -> o_set_res pulse at ack, o_done 3 cycles after accept, rd=0xDEADBEEF.
REQ-035 SC addr 0x100, i_gnt=1, rs2=0x5 -> o_check_res pulse, write 0x5 to 0x100, o_wr_en at ack, rd=0.
REQ-036 SC with i_gnt=0 -> no o_mem_req, o_done 3 cycles after accept, rd=1.
REQ-037 AMOMIN mem=0xFFFF_FFFF, rs2=0x1 -> writes 0xFFFF_FFFF, rd=0xFFFF_FFFF; AMOMINU same -> writes 0x1.
REQ-038 AMOADD, ack delayed 3 cycles each phase -> req/addr/wdata stable until ack; wrap 0xFFFF_FFFF+1 writes 0.
REQ-039 Reset asserted in STORE -> req low next cycle, no o_done/o_wr_en; addr 0x102 -> o_err, no req.
